// File: rtl/mem_access_pkg.sv
// Shared encodings and helpers for the core-side memory access master.
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StRead,
    StDone
  } state_t;

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: byte_en = 4'b0001 << lane;
      SZ_HALF: byte_en = lane[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  // Replicate right-justified store data onto every lane it could target.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] d);
    case (size)
      SZ_BYTE: store_data = {4{d[7:0]}};
      SZ_HALF: store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed lane of a bus word and sign/zero-extends it to 32 bits.
module load_extend
  import mem_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    shifted = word >> {lane, 3'b000};
    case (size)
      SZ_BYTE: result = is_unsigned ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: result = is_unsigned ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_master.sv
// Turns one core load/store into a single word-addressed bus transaction and
// returns the extended load result with a one-cycle completion pulse.
module mem_access_master
  import mem_access_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iReq,
  output logic        oReady,
  input  logic        iWrite,
  input  logic [1:0]  iSize,
  input  logic        iUnsigned,
  input  logic [31:0] iAddr,
  input  logic [31:0] iData,
  output logic        oDone,
  output logic [31:0] oData,
  output logic        oMisaligned,
  output logic [31:0] oBadAddr,
  output logic        wReadEnable,
  output logic        wWriteEnable,
  output logic [3:0]  wByteEnable,
  output logic [31:0] wAddress,
  output logic [31:0] wWriteData,
  input  logic [31:0] wReadData
);

  localparam int unsigned CntW = $clog2(READ_LATENCY) + 1;

  state_t          state_q, state_d;
  logic [CntW-1:0] cnt_q;
  logic [1:0]      lane_q, size_q;
  logic            uns_q, mis_q;
  logic [3:0]      be_q;
  logic [31:0]     data_q, bad_addr_q, waddr_q, wdata_q;
  logic [31:0]     ext_data;
  logic            fault, accept, read_last;

  assign fault = (iSize == SZ_ILL) || ((iSize == SZ_HALF) && iAddr[0]) ||
                 ((iSize == SZ_WORD) && (iAddr[1:0] != 2'b00));
  assign accept    = (state_q == StIdle) && iReq;
  assign read_last = (state_q == StRead) && (cnt_q == '0);

  load_extend u_load_extend (
    .word        (wReadData),
    .lane        (lane_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .result      (ext_data)
  );

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (iReq) state_d = fault ? StDone : (iWrite ? StWrite : StRead);
      StWrite: state_d = StDone;
      StRead:  if (cnt_q == '0) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Bus registers only move on a legal accept so a fault never disturbs the bus.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      cnt_q      <= '0;
      lane_q     <= 2'b00;
      size_q     <= SZ_BYTE;
      uns_q      <= 1'b0;
      mis_q      <= 1'b0;
      be_q       <= 4'h0;
      data_q     <= 32'h0;
      bad_addr_q <= 32'h0;
      waddr_q    <= 32'h0;
      wdata_q    <= 32'h0;
    end else begin
      if (accept) begin
        lane_q <= iAddr[1:0];
        size_q <= iSize;
        uns_q  <= iUnsigned;
        mis_q  <= fault;
        cnt_q  <= CntW'(READ_LATENCY - 1);
        if (fault) begin
          bad_addr_q <= iAddr;
        end else begin
          waddr_q <= {iAddr[31:2], 2'b00};
          be_q    <= byte_en(iSize, iAddr[1:0]);
          if (iWrite) wdata_q <= store_data(iSize, iData);
        end
      end else if ((state_q == StRead) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (read_last) data_q <= ext_data;
    end
  end

  always_comb begin
    oReady       = (state_q == StIdle);
    oDone        = (state_q == StDone);
    oMisaligned  = (state_q == StDone) && mis_q;
    wWriteEnable = (state_q == StWrite);
    wReadEnable  = (state_q == StRead);
    wByteEnable  = ((state_q == StWrite) || (state_q == StRead)) ? be_q : 4'h0;
  end

  assign oData      = data_q;
  assign oBadAddr   = bad_addr_q;
  assign wAddress   = waddr_q;
  assign wWriteData = wdata_q;

endmodule

// File: tb/tb_mem_access_master.sv
// Directed bench for mem_access_master with a 3-cycle read latency.
module tb_mem_access_master;

  localparam int unsigned LAT = 3;

  logic        iCLK, iRST, iReq, iWrite, iUnsigned;
  logic [1:0]  iSize;
  logic [31:0] iAddr, iData, wReadData;
  logic        oReady, oDone, oMisaligned, wReadEnable, wWriteEnable;
  logic [31:0] oData, oBadAddr, wAddress, wWriteData;
  logic [3:0]  wByteEnable;

  int checks = 0;
  int errors = 0;

  mem_access_master #(.READ_LATENCY(LAT)) dut (
    .iCLK         (iCLK),
    .iRST         (iRST),
    .iReq         (iReq),
    .oReady       (oReady),
    .iWrite       (iWrite),
    .iSize        (iSize),
    .iUnsigned    (iUnsigned),
    .iAddr        (iAddr),
    .iData        (iData),
    .oDone        (oDone),
    .oData        (oData),
    .oMisaligned  (oMisaligned),
    .oBadAddr     (oBadAddr),
    .wReadEnable  (wReadEnable),
    .wWriteEnable (wWriteEnable),
    .wByteEnable  (wByteEnable),
    .wAddress     (wAddress),
    .wWriteData   (wWriteData),
    .wReadData    (wReadData)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] d,
                          input logic [3:0] be, input logic [31:0] wd, input logic [31:0] held,
                          input string tag);
    @(negedge iCLK);
    iReq = 1'b1; iWrite = 1'b1; iSize = size; iUnsigned = 1'b0; iAddr = addr; iData = d;
    @(negedge iCLK);
    iReq = 1'b0;
    chk({tag, "_c1_we"}, 32'(wWriteEnable), 32'd1);
    chk({tag, "_c1_re"}, 32'(wReadEnable), 32'd0);
    chk({tag, "_c1_be"}, 32'(wByteEnable), 32'(be));
    chk({tag, "_c1_addr"}, wAddress, {addr[31:2], 2'b00});
    chk({tag, "_c1_wdata"}, wWriteData, wd);
    chk({tag, "_c1_done"}, 32'(oDone), 32'd0);
    @(negedge iCLK);
    chk({tag, "_c2_we"}, 32'(wWriteEnable), 32'd0);
    chk({tag, "_c2_be"}, 32'(wByteEnable), 32'd0);
    chk({tag, "_c2_done"}, 32'(oDone), 32'd1);
    chk({tag, "_c2_mis"}, 32'(oMisaligned), 32'd0);
    chk({tag, "_c2_odata_held"}, oData, held);
    @(negedge iCLK);
    chk({tag, "_c3_ready"}, 32'(oReady), 32'd1);
    chk({tag, "_c3_done"}, 32'(oDone), 32'd0);
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                         input logic [31:0] rdata, input logic [3:0] be, input logic [31:0] exp,
                         input string tag);
    int re_cnt;
    @(negedge iCLK);
    iReq = 1'b1; iWrite = 1'b0; iSize = size; iUnsigned = uns; iAddr = addr; iData = 32'h0;
    wReadData = 32'hDEADBEEF;
    re_cnt = 0;
    for (int c = 1; c <= LAT; c++) begin
      @(negedge iCLK);
      iReq = 1'b0;
      if (wReadEnable === 1'b1) re_cnt++;
      if (c == 1) begin
        chk({tag, "_be"}, 32'(wByteEnable), 32'(be));
        chk({tag, "_addr"}, wAddress, {addr[31:2], 2'b00});
        chk({tag, "_we"}, 32'(wWriteEnable), 32'd0);
      end
      // Only the final read cycle carries the real data.
      wReadData = (c == LAT) ? rdata : 32'hDEADBEEF;
    end
    @(negedge iCLK);
    wReadData = 32'hDEADBEEF;
    chk({tag, "_re_cycles"}, 32'(re_cnt), 32'(LAT));
    chk({tag, "_re_off"}, 32'(wReadEnable), 32'd0);
    chk({tag, "_done"}, 32'(oDone), 32'd1);
    chk({tag, "_data"}, oData, exp);
    chk({tag, "_mis"}, 32'(oMisaligned), 32'd0);
    @(negedge iCLK);
    chk({tag, "_ready"}, 32'(oReady), 32'd1);
  endtask

  task automatic do_fault(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                          input string tag);
    @(negedge iCLK);
    iReq = 1'b1; iWrite = wr; iSize = size; iUnsigned = 1'b0; iAddr = addr; iData = 32'h55AA55AA;
    @(negedge iCLK);
    iReq = 1'b0;
    chk({tag, "_we"}, 32'(wWriteEnable), 32'd0);
    chk({tag, "_re"}, 32'(wReadEnable), 32'd0);
    chk({tag, "_be"}, 32'(wByteEnable), 32'd0);
    chk({tag, "_done"}, 32'(oDone), 32'd1);
    chk({tag, "_mis"}, 32'(oMisaligned), 32'd1);
    chk({tag, "_badaddr"}, oBadAddr, addr);
    @(negedge iCLK);
    chk({tag, "_ready"}, 32'(oReady), 32'd1);
    chk({tag, "_mis_clr"}, 32'(oMisaligned), 32'd0);
  endtask

  initial begin
    int n_we, n_done, n_ready;
    iRST = 1'b1; iReq = 1'b0; iWrite = 1'b0; iSize = 2'b00; iUnsigned = 1'b0;
    iAddr = 32'h0; iData = 32'h0; wReadData = 32'h0;

    // Reset state
    @(negedge iCLK);
    chk("rst_ready", 32'(oReady), 32'd1);
    chk("rst_done", 32'(oDone), 32'd0);
    chk("rst_mis", 32'(oMisaligned), 32'd0);
    chk("rst_re", 32'(wReadEnable), 32'd0);
    chk("rst_we", 32'(wWriteEnable), 32'd0);
    chk("rst_be", 32'(wByteEnable), 32'd0);
    chk("rst_odata", oData, 32'h0);
    chk("rst_badaddr", oBadAddr, 32'h0);
    chk("rst_waddr", wAddress, 32'h0);
    chk("rst_wdata", wWriteData, 32'h0);
    iRST = 1'b0;

    do_store(32'h00002003, 2'b00, 32'h000000A5, 4'b1000, 32'hA5A5A5A5, 32'h0, "st_byte");
    do_load(32'h00002001, 2'b00, 1'b0, 32'h1234F678, 4'b0010, 32'hFFFFFFF6, "ld_sb");
    do_load(32'h00002001, 2'b00, 1'b1, 32'h1234F678, 4'b0010, 32'h000000F6, "ld_ub");
    do_load(32'h00002002, 2'b01, 1'b0, 32'h8001ABCD, 4'b1100, 32'hFFFF8001, "ld_sh");
    do_load(32'h00002002, 2'b01, 1'b1, 32'h8001ABCD, 4'b1100, 32'h00008001, "ld_uh");
    do_load(32'h00002000, 2'b01, 1'b0, 32'h8001ABCD, 4'b0011, 32'hFFFFABCD, "ld_sh_lo");
    do_load(32'h00002004, 2'b10, 1'b0, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D, "ld_w");
    do_store(32'h00002002, 2'b01, 32'h1234BEEF, 4'b1100, 32'hBEEFBEEF, 32'hCAFEF00D, "st_half");
    do_store(32'h00002008, 2'b10, 32'h01020304, 4'b1111, 32'h01020304, 32'hCAFEF00D, "st_word");

    do_fault(1'b1, 2'b10, 32'h00002002, "flt_word");
    do_fault(1'b0, 2'b11, 32'h00003000, "flt_ill");
    do_fault(1'b0, 2'b01, 32'h00002001, "flt_half");

    // iReq held high: accepts only in IDLE, one strobe and one completion each
    @(negedge iCLK);
    iReq = 1'b1; iWrite = 1'b1; iSize = 2'b10; iAddr = 32'h00004000; iData = 32'h11223344;
    n_we = 0; n_done = 0; n_ready = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge iCLK);
      if (wWriteEnable === 1'b1) n_we++;
      if (oDone === 1'b1) n_done++;
      if (oReady === 1'b1) n_ready++;
    end
    iReq = 1'b0;
    chk("held_we_count", 32'(n_we), 32'd3);
    chk("held_done_count", 32'(n_done), 32'd3);
    chk("held_ready_count", 32'(n_ready), 32'd2);
    @(negedge iCLK);
    chk("held_idle_ready", 32'(oReady), 32'd1);
    chk("held_idle_we", 32'(wWriteEnable), 32'd0);

    // Reset during the second read cycle
    @(negedge iCLK);
    iReq = 1'b1; iWrite = 1'b0; iSize = 2'b10; iUnsigned = 1'b0; iAddr = 32'h00005000;
    wReadData = 32'h77777777;
    @(negedge iCLK);
    iReq = 1'b0;
    chk("rstmid_c1_re", 32'(wReadEnable), 32'd1);
    @(negedge iCLK);
    iRST = 1'b1;
    #1;
    chk("rstmid_re", 32'(wReadEnable), 32'd0);
    chk("rstmid_be", 32'(wByteEnable), 32'd0);
    chk("rstmid_done", 32'(oDone), 32'd0);
    chk("rstmid_ready", 32'(oReady), 32'd1);
    @(negedge iCLK);
    iRST = 1'b0;
    n_done = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge iCLK);
      if (oDone === 1'b1) n_done++;
    end
    chk("rstmid_no_done", 32'(n_done), 32'd0);
    chk("rstmid_ready_after", 32'(oReady), 32'd1);
    chk("rstmid_odata", oData, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
